// File: rtl/layer2_sequencer.sv
// Output-layer sequencer: streams hidden/weight addresses per output neuron, adds bias, emits scores.
// Define L2SEQ_ARGMAX_EN to build the running argmax that drives class_out.
module layer2_sequencer #(
   parameter int NWBITS     = 16,
   parameter int NHIDDEN    = 256,
   parameter int COUNT_BIT2 = 8,
   parameter int NOUT       = 10,
   parameter int OBIT       = 4,
   parameter int SUMBITS    = 50
) (
   input  logic                       clk,
   input  logic                       reset_b,
   input  logic                       start,
   output logic                       busy,
   output logic [COUNT_BIT2-1:0]      hidden_addr,
   output logic [OBIT+COUNT_BIT2-1:0] weight_addr,
   output logic [OBIT-1:0]            bias_addr,
   input  logic [NWBITS-1:0]          bias,
   output logic                       start_multiply,
   input  logic                       add_bias,
   input  logic [SUMBITS-1:0]         weighted_sum,
   output logic                       score_valid,
   output logic [OBIT-1:0]            score_idx,
   output logic [SUMBITS-1:0]         score,
   output logic [OBIT-1:0]            class_out,
   output logic                       done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SCORE} state_t;

   state_t                  state, state_nx;
   logic [OBIT-1:0]         n, n_nx;
   logic [COUNT_BIT2-1:0]   h, h_nx;
   logic                    score_ld;
   logic                    last_n;
   logic                    mult_q;
   logic [SUMBITS-1:0]      score_q;
   logic [SUMBITS-1:0]      bias_ext;

   assign last_n   = (n == OBIT'(NOUT - 1));
   assign bias_ext = {{(SUMBITS-NWBITS){bias[NWBITS-1]}}, bias};

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state   <= IDLE;
         n       <= '0;
         h       <= '0;
         mult_q  <= 1'b0;
         score_q <= '0;
      end else begin
         state   <= state_nx;
         n       <= n_nx;
         h       <= h_nx;
         // first product leaves the memories one cycle after h=0 is issued
         mult_q  <= (state == ISSUE) && (h == '0);
         if (score_ld)
            score_q <= weighted_sum + bias_ext;
      end
   end

   always_comb begin
      state_nx = state;
      n_nx     = n;
      h_nx     = h;
      score_ld = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = ISSUE;
               n_nx     = '0;
               h_nx     = '0;
            end
         end
         ISSUE: begin
            if (h == COUNT_BIT2'(NHIDDEN - 1)) begin
               state_nx = DRAIN;
               h_nx     = '0;
            end else begin
               h_nx = h + COUNT_BIT2'(1);
            end
         end
         DRAIN: begin
            if (add_bias) begin
               state_nx = SCORE;
               score_ld = 1'b1;
            end
         end
         SCORE: begin
            if (last_n) begin
               state_nx = IDLE;
               n_nx     = '0;
            end else begin
               state_nx = ISSUE;
               n_nx     = n + OBIT'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy           = (state != IDLE);
   assign hidden_addr    = h;
   assign weight_addr    = {n, h};
   assign bias_addr      = n;
   assign start_multiply = mult_q;
   assign score_valid    = (state == SCORE);
   assign score_idx      = score_valid ? n : '0;
   assign score          = score_q;
   assign done           = score_valid && last_n;

`ifdef L2SEQ_ARGMAX_EN
   localparam logic [SUMBITS-1:0] MOST_NEG = {1'b1, {(SUMBITS-1){1'b0}}};

   logic [SUMBITS-1:0] max_q;
   logic [OBIT-1:0]    max_idx_q;
   logic [OBIT-1:0]    class_q;
   logic               take;

   assign take = $signed(score_q) > $signed(max_q);

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         max_q     <= MOST_NEG;
         max_idx_q <= '0;
         class_q   <= '0;
      end else if (state == IDLE && start) begin
         max_q     <= MOST_NEG;
         max_idx_q <= '0;
      end else if (state == SCORE) begin
         if (take) begin
            max_q     <= score_q;
            max_idx_q <= n;
         end
         if (last_n)
            class_q <= take ? n : max_idx_q;
      end
   end

   // the final comparison is folded in combinationally so class_out is valid during done
   assign class_out = done ? (take ? n : max_idx_q) : class_q;
`else
   assign class_out = '0;
`endif

endmodule

// File: tb/tb_layer2_sequencer.sv
// Self-checking bench for layer2_sequencer: cycle-arithmetic reference model plus memory/datapath models.
module tb_layer2_sequencer;
   localparam int NW  = 16;
   localparam int NH  = 4;
   localparam int CB  = 2;
   localparam int NO  = 3;
   localparam int OB  = 2;
   localparam int SB  = 2*NW + 10 + CB;
   localparam int P   = NH + 3;
   localparam int DNH = 256;
   localparam int DCB = 8;
   localparam int DNO = 10;
   localparam int DOB = 4;
   localparam int DSB = 2*NW + 10 + DCB;
   localparam int DP  = DNH + 3;
`ifdef L2SEQ_ARGMAX_EN
   localparam bit AM = 1'b1;
`else
   localparam bit AM = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- small instance ----------------
   logic                    reset_b, start, busy, start_multiply, add_bias, score_valid, done;
   logic [CB-1:0]           hidden_addr;
   logic [OB+CB-1:0]        weight_addr;
   logic [OB-1:0]           bias_addr, score_idx, class_out;
   logic signed [NW-1:0]    bias;
   logic signed [SB-1:0]    weighted_sum, score;

   layer2_sequencer #(.NWBITS(NW), .NHIDDEN(NH), .COUNT_BIT2(CB), .NOUT(NO), .OBIT(OB), .SUMBITS(SB)) dut (
      .clk(clk), .reset_b(reset_b), .start(start), .busy(busy),
      .hidden_addr(hidden_addr), .weight_addr(weight_addr), .bias_addr(bias_addr), .bias(bias),
      .start_multiply(start_multiply), .add_bias(add_bias), .weighted_sum(weighted_sum),
      .score_valid(score_valid), .score_idx(score_idx), .score(score), .class_out(class_out), .done(done));

   logic signed [NW-1:0] hid  [NH];
   logic signed [NW-1:0] wmem [1<<(OB+CB)];
   logic signed [NW-1:0] bmem [1<<OB];

   // synchronous memories and a multiply-accumulate datapath reacting to the DUT
   logic signed [NW-1:0] rd_h, rd_w, rd_b;
   logic signed [SB-1:0] prod, dp_acc, dp_sum, spur_sum;
   int                   dp_cnt;
   logic                 dp_strobe;
   logic                 spur = 1'b0;
   logic                 spur_en = 1'b0;

   assign prod         = rd_h * rd_w;
   assign bias         = rd_b;
   assign add_bias     = dp_strobe | spur;
   assign weighted_sum = spur ? spur_sum : dp_sum;

   always @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rd_h <= '0; rd_w <= '0; rd_b <= '0;
         dp_strobe <= 1'b0; dp_sum <= '0;
         dp_acc = '0; dp_cnt = 0;
      end else begin
         rd_h <= hid[hidden_addr];
         rd_w <= wmem[weight_addr];
         rd_b <= bmem[bias_addr];
         dp_strobe <= 1'b0;
         if (start_multiply) begin
            dp_acc = prod; dp_cnt = 1;
         end else if (dp_cnt != 0) begin
            dp_acc = dp_acc + prod; dp_cnt++;
         end
         if (dp_cnt == NH) begin
            dp_sum <= dp_acc; dp_strobe <= 1'b1; dp_cnt = 0;
         end
      end
   end

   // stray strobes only while products are still streaming (DUT is in ISSUE)
   always @(negedge clk) begin
      spur     = spur_en && dp_cnt >= 1 && dp_cnt <= NH-2 && ($urandom_range(0, 1) == 1);
      spur_sum = SB'($urandom);
   end

   function automatic logic signed [SB-1:0] exp_score(input int k);
      logic signed [SB-1:0] s;
      s = '0;
      for (int j = 0; j < NH; j++)
         s = s + hid[j] * wmem[k*NH + j];
      s = s + bmem[k];
      return s;
   endfunction

   function automatic int exp_class();
      int best;
      best = 0;
      for (int k = 1; k < NO; k++)
         if (exp_score(k) > exp_score(best)) best = k;
      return AM ? best : 0;
   endfunction

   // reference model: cycle index within the current inference, -1 when idle
   int run_cyc = -1;
   int class_hold = 0;
   always @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         run_cyc = -1; class_hold = 0;
      end else if (run_cyc < 0) begin
         if (start) run_cyc = 1;
      end else if (run_cyc == NO*P) begin
         run_cyc = -1; class_hold = exp_class();
      end else begin
         run_cyc++;
      end
   end

   logic signed [SB-1:0] sc_q[$];
   int                   sc_cyc_q[$];
   int                   done_cnt = 0;
   int                   done_cyc = 0;
   int                   class_at_done = 0;

   always @(negedge clk) begin
      int  k, r;
      bit  in_run, sv, dn;
      in_run = run_cyc >= 1;
      k = in_run ? (run_cyc-1) / P : 0;
      r = in_run ? (run_cyc-1) % P : -1;
      sv = in_run && r == NH+2;
      dn = sv && k == NO-1;
      chk("busy", busy, in_run);
      chk("start_multiply", start_multiply, in_run && r == 1);
      chk("score_valid", score_valid, sv);
      chk("done", done, dn);
      if (in_run && r < NH) begin
         chk("hidden_addr", hidden_addr, r);
         chk("weight_addr", weight_addr, k*NH + r);
         chk("bias_addr", bias_addr, k);
      end
      if (sv) begin
         chk("score_idx", score_idx, k);
         chk("score", score, exp_score(k));
         sc_q.push_back(score);
         sc_cyc_q.push_back(run_cyc);
      end
      chk("class_out", class_out, dn ? exp_class() : class_hold);
      if (dn) begin
         done_cnt++; done_cyc = run_cyc; class_at_done = int'(class_out);
      end
   end

   task automatic wait_done(input bit noise);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2*NO*P + 10 && !seen; i++) begin
         @(negedge clk);
         if (noise) start = ($urandom_range(0, 3) == 0);
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic load_plan();
      for (int k = 0; k < NO; k++) begin
         bmem[k] = '0;
         for (int j = 0; j < NH; j++) begin
            hid[j] = 16'sd1;
            wmem[k*NH + j] = NW'(k);
         end
      end
   endtask

   task automatic check_plan(input string tag);
      chk({tag, "_nscores"}, sc_q.size(), 3);
      if (sc_q.size() == 3) begin
         chk({tag, "_s0"}, sc_q[0], 0);
         chk({tag, "_s1"}, sc_q[1], 4);
         chk({tag, "_s2"}, sc_q[2], 8);
         chk({tag, "_c0"}, sc_cyc_q[0], 7);
         chk({tag, "_c1"}, sc_cyc_q[1], 14);
         chk({tag, "_c2"}, sc_cyc_q[2], 21);
      end
      chk({tag, "_done_cyc"}, done_cyc, 21);
      chk({tag, "_class"}, class_at_done, AM ? 2 : 0);
   endtask

   task automatic run_main();
      int d0;
      reset_b = 1'b0; start = 1'b0;
      for (int i = 0; i < (1<<(OB+CB)); i++) wmem[i] = '0;
      for (int i = 0; i < (1<<OB); i++) bmem[i] = '0;
      for (int i = 0; i < NH; i++) hid[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset_score", score, 0);
      chk("reset_busy", busy, 0);
      reset_b = 1'b1;
      load_plan();

      // reset in the middle of ISSUE
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); #1 reset_b = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_haddr", hidden_addr, 0);
      chk("midrst_waddr", weight_addr, 0);
      chk("midrst_done", done, 0);
      @(negedge clk); reset_b = 1'b1;

      sc_q.delete(); sc_cyc_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(1'b0); #1;
      check_plan("plan");

      // negative bias: 4*25*1 - 300 = -200
      for (int j = 0; j < NH; j++) begin
         hid[j] = 16'sd25; wmem[j] = 16'sd1; wmem[NH+j] = 16'sd0; wmem[2*NH+j] = 16'sd2;
      end
      bmem[0] = -16'sd300; bmem[1] = 16'sd7; bmem[2] = 16'sd0;
      sc_q.delete(); sc_cyc_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(1'b0); #1;
      chk("negbias_s0", sc_q.size() > 0 ? sc_q[0] : 0, -200);
      chk("negbias_class", class_at_done, AM ? 2 : 0);

      // ties: every neuron scores 5
      for (int k = 0; k < NO; k++) begin
         bmem[k] = '0;
         for (int j = 0; j < NH; j++) begin
            hid[j] = 16'sd1; wmem[k*NH+j] = (j == 0) ? 16'sd2 : 16'sd1;
         end
      end
      sc_q.delete(); sc_cyc_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(1'b0); #1;
      chk("tie_s2", sc_q.size() == 3 ? sc_q[2] : 0, 5);
      chk("tie_class", class_at_done, 0);

      // stray add_bias during ISSUE must not disturb the scores
      load_plan();
      spur_en = 1'b1;
      sc_q.delete(); sc_cyc_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(1'b0); #1;
      spur_en = 1'b0;
      check_plan("spur");

      // start held high: one run, then a new one accepted right after busy falls
      sc_q.delete(); sc_cyc_q.delete();
      @(negedge clk); start = 1'b1;
      wait_done(1'b0); #1;
      d0 = done_cnt;
      chk("held_nscores", sc_q.size(), 3);
      @(negedge clk);
      chk("held_gap_busy", busy, 0);
      @(negedge clk); start = 1'b0;
      chk("held_rerun_busy", busy, 1);
      wait_done(1'b0); #1;
      chk("held_done_count", done_cnt, d0 + 1);

      // randomized runs with start noise, stray strobes and one mid-run reset
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         for (int j = 0; j < NH; j++) hid[j] = NW'($urandom);
         for (int i = 0; i < NO*NH; i++) wmem[i] = NW'($urandom);
         for (int k = 0; k < NO; k++) bmem[k] = NW'($urandom);
         spur_en = ($urandom_range(0, 1) == 1);
         start = 1'b1;
         @(negedge clk); start = 1'b0;
         if (t == 3) begin
            repeat ($urandom_range(1, 18)) @(negedge clk);
            #1 reset_b = 1'b0;
            @(negedge clk); reset_b = 1'b1;
         end else begin
            wait_done(1'b1);
         end
         start = 1'b0;
      end
      spur_en = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- default-parameter instance ----------------
   logic                  reset_b2, start2, busy2, start_multiply2, add_bias2, score_valid2, done2;
   logic [DCB-1:0]        hidden_addr2;
   logic [DOB+DCB-1:0]    weight_addr2;
   logic [DOB-1:0]        bias_addr2, score_idx2, class_out2;
   logic [NW-1:0]         bias2;
   logic [DSB-1:0]        weighted_sum2, score2;
   int                    cnt2;

   assign bias2         = '0;
   assign weighted_sum2 = '0;

   layer2_sequencer dut_def (
      .clk(clk), .reset_b(reset_b2), .start(start2), .busy(busy2),
      .hidden_addr(hidden_addr2), .weight_addr(weight_addr2), .bias_addr(bias_addr2), .bias(bias2),
      .start_multiply(start_multiply2), .add_bias(add_bias2), .weighted_sum(weighted_sum2),
      .score_valid(score_valid2), .score_idx(score_idx2), .score(score2), .class_out(class_out2), .done(done2));

   always @(posedge clk or negedge reset_b2) begin
      if (!reset_b2) begin
         cnt2 = 0; add_bias2 <= 1'b0;
      end else begin
         add_bias2 <= 1'b0;
         if (start_multiply2) cnt2 = 1;
         else if (cnt2 != 0) cnt2++;
         if (cnt2 == DNH) begin
            add_bias2 <= 1'b1; cnt2 = 0;
         end
      end
   end

   task automatic run_default();
      int  c, k, r, sm_n;
      bit  seen;
      reset_b2 = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      reset_b2 = 1'b1;
      @(negedge clk); start2 = 1'b1;
      chk("def_idle_busy", busy2, 0);
      @(negedge clk); start2 = 1'b0;
      c = 1; sm_n = 0; seen = 1'b0;
      while (!seen && c <= DNO*DP + 5) begin
         k = (c-1) / DP; r = (c-1) % DP;
         chk("def_busy", busy2, 1);
         if (r < DNH) begin
            chk("def_weight_addr", weight_addr2, k*DNH + r);
            chk("def_hidden_addr", hidden_addr2, r);
            chk("def_bias_addr", bias_addr2, k);
         end
         chk("def_start_multiply", start_multiply2, r == 1);
         if (start_multiply2 === 1'b1) sm_n++;
         chk("def_score_valid", score_valid2, r == DNH+2);
         if (score_valid2 === 1'b1) begin
            chk("def_score_idx", score_idx2, k);
            chk("def_score", score2, 0);
         end
         if (done2 === 1'b1) begin
            seen = 1'b1;
            chk("def_done_cycle", c, 2590);
            chk("def_class", class_out2, 0);
         end else begin
            @(negedge clk); c++;
         end
      end
      if (!seen) chk("def_done_timeout", 0, 1);
      chk("def_mult_pulses", sm_n, 10);
      @(negedge clk);
      chk("def_busy_after", busy2, 0);
   endtask

   initial begin
      fork
         run_main();
         run_default();
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/layer2_sequencer.md
# layer2_sequencer

Sequencing controller for the second (output) layer of the MNIST network. It walks all NOUT output neurons in turn. For each neuron it streams NHIDDEN hidden-activation and weight read addresses to synchronous memories, and fires the one-cycle start pulse of the downstream multiply-accumulate datapath. It then waits for that datapath's completion strobe, adds the neuron's bias and emits one score per neuron. An optional running argmax yields the classified digit.

## Interface
Parameters:
- NWBITS, 16, weight/bias width
- NHIDDEN, 256, hidden neurons per output (power of two, ≥2)
- COUNT_BIT2, 8, log2(NHIDDEN)
- NOUT, 10, output neurons
- OBIT, 4, ceil(log2(NOUT))
- SUMBITS, 50, weighted-sum/score width (2*NWBITS+10+COUNT_BIT2)

Ports (reset reset_b, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge
- reset_b  in  1  asynchronous active-low reset
- start  in  1  begin one inference; sampled only in IDLE
- busy  out  1  high from cycle after accepted start until done
- hidden_addr  out  COUNT_BIT2  hidden-buffer read address
- weight_addr  out  OBIT+COUNT_BIT2  weight-ROM address = {neuron, hidden_addr}
- bias_addr  out  OBIT  bias-ROM address = current neuron
- bias  in  NWBITS  signed bias data, 1-cycle read latency
- start_multiply  out  1  1-cycle pulse, coincident with first product
- add_bias  in  1  datapath done strobe, weighted_sum valid same cycle
- weighted_sum  in  SUMBITS  signed accumulated sum
- score_valid  out  1  1-cycle pulse per neuron
- score_idx  out  OBIT  neuron index of score
- score  out  SUMBITS  signed weighted_sum + sign-extended bias
- class_out  out  OBIT  argmax index, valid with done
- done  out  1  1-cycle pulse, inference complete

## Operation
- States: IDLE, ISSUE, DRAIN, SCORE.
- IDLE: start=1 → neuron n=0, h=0, go ISSUE. start in any other state is ignored.
- ISSUE: hidden_addr=h, weight_addr={n,h}, bias_addr=n. h increments every cycle with no stalls; the datapath consumes one product per cycle unconditionally. After h=NHIDDEN-1, go DRAIN.
- start_multiply = ISSUE-first-cycle delayed one cycle (memory latency). Exactly one pulse per neuron.
- DRAIN: wait for add_bias=1. On add_bias=1, latch score = weighted_sum + sign_extend(bias) to SUMBITS, then go SCORE. add_bias outside DRAIN is ignored (datapath strobe register is not reset).
- SCORE: score_valid=1, score_idx=n. If n=NOUT-1, pulse done and go IDLE; else n+1, h=0, go ISSUE.
- Addition is two's complement, wraps at SUMBITS with no saturation (cannot overflow at default widths).
- Reset values: all outputs 0; state IDLE; n=h=0; argmax max register = most negative value.
- Reset mid-operation: immediate IDLE, all outputs 0, no score or done emitted. The datapath shares reset_b.

## Timing
- start sampled at cycle 0. Neuron k ISSUE occupies cycles 1+k·P .. NHIDDEN+k·P, with P = NHIDDEN+3.
- start_multiply at cycle 2+k·P. add_bias arrives at NHIDDEN+2+k·P. score_valid at NHIDDEN+3+k·P.
- done coincides with the last score_valid: cycle NOUT·P. With defaults that is 2590.
- busy falls in the cycle after done. A new start is accepted from that cycle.

## Configuration
- L2SEQ_ARGMAX_EN defined: running max over scores. Strictly greater replaces the max, so a tie keeps the lower index. class_out updates when done is high and holds until the next done or reset.
- Not defined: comparator and max registers are removed. class_out is tied to 0. All other behaviour is identical.

## Test plan
- Reset mid-ISSUE (NHIDDEN=4, NOUT=3), assert reset_b=0 at cycle 3 → all outputs 0 next cycle. New start then gives a full clean run, done at cycle 21.
- NHIDDEN=4, NOUT=3, all hidden=1, weights=neuron index, biases 0 → scores 0,4,8 at cycles 7,14,21. done at 21, class_out=2 with L2SEQ_ARGMAX_EN.
- Address sequence check, defaults → weight_addr runs 0..255 for neuron 0, then 256..511 for neuron 1. Exactly one start_multiply per neuron, at cycle 2+k·259.
- Negative bias: sum 100, bias -300 → score -200 (sign-extended). Ties: scores 5,5,5 → class_out=0.
- start held high throughout a run → only one inference. start re-asserted the cycle after done falls → second run accepted.
- Spurious add_bias=1 injected during ISSUE → ignored. The score equals the value latched at the genuine strobe.
